// File: rtl/serial_cmd_decoder_core.sv
// Frame decoder: pops FF FF 00 LEN payload EE EE from a byte FIFO and latches up to 8 payload bytes.
// Optional ack watchdog in DONE: define SERIAL_CMD_DECODER_ACK_TIMEOUT_EN.
module serial_cmd_decoder_core #(
  parameter int MAX_CMD_PAYLOAD_BYTES = 8,
  parameter int ACK_TIMEOUT_CYCLES    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_ready,
  input  logic [7:0] data,
  input  logic       cmd_processed_received,
  output logic       cmd_read_clk,
  output logic       cmd_processed,
  output logic [7:0] cmd_bytes_processed,
  output logic       cmd_decode_success,
  output logic [7:0] cmd_payload_r0,
  output logic [7:0] cmd_payload_r1,
  output logic [7:0] cmd_payload_r2,
  output logic [7:0] cmd_payload_r3,
  output logic [7:0] cmd_payload_r4,
  output logic [7:0] cmd_payload_r5,
  output logic [7:0] cmd_payload_r6,
  output logic [7:0] cmd_payload_r7
);

`ifdef SERIAL_CMD_DECODER_ACK_TIMEOUT_EN
  localparam bit ACK_TIMEOUT_EN = 1'b1;
`else
  localparam bit ACK_TIMEOUT_EN = 1'b0;
`endif
  localparam int ACK_CNT_W = $clog2(ACK_TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, POP, LATCH, DONE} state_t;

  state_t               state_reg, state_next;
  logic [3:0]           k_reg, k_next;
  logic [3:0]           len_reg, len_next;
  logic [7:0]           payload_reg [8];
  logic [7:0]           payload_next [8];
  logic [7:0]           bytes_reg, bytes_next;
  logic                 success_reg, success_next;
  logic                 read_reg, processed_reg;
  logic                 ready_prev_reg;
  logic [ACK_CNT_W-1:0] ack_cnt_reg, ack_cnt_next;
  logic [3:0]           pl_idx;

  assign pl_idx = k_reg - 4'd4;

  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    len_next     = len_reg;
    payload_next = payload_reg;
    bytes_next   = bytes_reg;
    success_next = success_reg;
    ack_cnt_next = '0;
    case (state_reg)
      IDLE: begin
        if (cmd_ready && !ready_prev_reg) begin
          for (int i = 0; i < 8; i++) payload_next[i] = 8'h00;
          bytes_next   = 8'h00;
          success_next = 1'b0;
          k_next       = 4'd0;
          len_next     = 4'd0;
          state_next   = POP;
        end
      end
      POP: begin
        bytes_next = bytes_reg + 8'd1;
        state_next = LATCH;
      end
      LATCH: begin
        state_next = POP;
        k_next     = k_reg + 4'd1;
        // Any failing field falls through to DONE with success left at 0.
        if (k_reg < 4'd2) begin
          if (data != 8'hFF) state_next = DONE;
        end else if (k_reg == 4'd2) begin
          if (data != 8'h00) state_next = DONE;
        end else if (k_reg == 4'd3) begin
          if (data > 8'(MAX_CMD_PAYLOAD_BYTES)) state_next = DONE;
          else len_next = data[3:0];
        end else if (k_reg < 4'd4 + len_reg) begin
          payload_next[pl_idx[2:0]] = data;
        end else if (k_reg == 4'd4 + len_reg) begin
          if (data != 8'hEE) state_next = DONE;
        end else begin
          state_next = DONE;
          if (data == 8'hEE) success_next = 1'b1;
        end
      end
      DONE: begin
        ack_cnt_next = ack_cnt_reg + 1'b1;
        if (cmd_processed_received) state_next = IDLE;
        else if (ACK_TIMEOUT_EN && ack_cnt_reg == ACK_CNT_W'(ACK_TIMEOUT_CYCLES - 1))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      k_reg          <= 4'd0;
      len_reg        <= 4'd0;
      bytes_reg      <= 8'h00;
      success_reg    <= 1'b0;
      read_reg       <= 1'b0;
      processed_reg  <= 1'b0;
      ready_prev_reg <= 1'b0;
      ack_cnt_reg    <= '0;
      for (int i = 0; i < 8; i++) payload_reg[i] <= 8'h00;
    end else begin
      state_reg      <= state_next;
      k_reg          <= k_next;
      len_reg        <= len_next;
      bytes_reg      <= bytes_next;
      success_reg    <= success_next;
      read_reg       <= (state_next == POP);
      processed_reg  <= (state_next == DONE);
      ready_prev_reg <= cmd_ready;
      ack_cnt_reg    <= ack_cnt_next;
      for (int i = 0; i < 8; i++) payload_reg[i] <= payload_next[i];
    end
  end

  assign cmd_read_clk        = read_reg;
  assign cmd_processed       = processed_reg;
  assign cmd_bytes_processed = bytes_reg;
  assign cmd_decode_success  = success_reg;
  assign cmd_payload_r0      = payload_reg[0];
  assign cmd_payload_r1      = payload_reg[1];
  assign cmd_payload_r2      = payload_reg[2];
  assign cmd_payload_r3      = payload_reg[3];
  assign cmd_payload_r4      = payload_reg[4];
  assign cmd_payload_r5      = payload_reg[5];
  assign cmd_payload_r6      = payload_reg[6];
  assign cmd_payload_r7      = payload_reg[7];

endmodule

// File: tb/tb_serial_cmd_decoder_core.sv
// Directed bench for serial_cmd_decoder_core with a behavioural byte FIFO.
module tb_serial_cmd_decoder_core;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_ready;
  logic [7:0] data;
  logic       cmd_processed_received;
  logic       cmd_read_clk;
  logic       cmd_processed;
  logic [7:0] cmd_bytes_processed;
  logic       cmd_decode_success;
  logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;

  serial_cmd_decoder_core #(.MAX_CMD_PAYLOAD_BYTES(8), .ACK_TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cmd_ready(cmd_ready), .data(data),
    .cmd_processed_received(cmd_processed_received),
    .cmd_read_clk(cmd_read_clk), .cmd_processed(cmd_processed),
    .cmd_bytes_processed(cmd_bytes_processed), .cmd_decode_success(cmd_decode_success),
    .cmd_payload_r0(r0), .cmd_payload_r1(r1), .cmd_payload_r2(r2), .cmd_payload_r3(r3),
    .cmd_payload_r4(r4), .cmd_payload_r5(r5), .cmd_payload_r6(r6), .cmd_payload_r7(r7)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         c0;
  int         lat;
  int         pop_count;
  int         rd_ptr;
  logic [7:0] fifo_mem [32];

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO presents the next byte on the edge where it samples the pop strobe.
  always @(posedge clk) begin
    if (cmd_read_clk) begin
      data      <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [127:0] v, input int n);
    for (int i = 0; i < 32; i++) fifo_mem[i] = 8'h00;
    for (int i = 0; i < n; i++) fifo_mem[i] = v[127-8*i -: 8];
    rd_ptr    = 0;
    pop_count = 0;
  endtask

  task automatic start_decode();
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    c0 = cyc;
    cmd_ready = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!cmd_processed && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_processed) check_val("done_timeout", 32'(cmd_processed), 32'd1);
    lat = cyc - c0;
  endtask

  task automatic ack();
    @(negedge clk);
    cmd_processed_received = 1'b1;
    @(negedge clk);
    check_val("ack_drop", 32'(cmd_processed), 32'd0);
    cmd_processed_received = 1'b0;
  endtask

  task automatic report(input string tag);
    $display("%s: pops=%0d bytes=%0d success=%0d latency=%0d", tag, pop_count,
             cmd_bytes_processed, cmd_decode_success, lat);
  endtask

  initial begin
    int hi_cnt;
    rst = 1'b0;
    cmd_ready = 1'b0;
    cmd_processed_received = 1'b0;
    data = 8'h00;
    load(128'h0, 0);
    repeat (3) @(negedge clk);
    check_val("rst_outs", {cmd_read_clk, cmd_processed, cmd_decode_success, cmd_bytes_processed}, 32'd0);
    check_val("rst_payload", {r0, r1, r2, r3}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Valid frame, with a spurious cmd_ready edge during the decode
    load(128'hFFFF0006_01030B16_2121EEEE_00000000, 12);
    start_decode();
    repeat (3) @(negedge clk);
    cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    cmd_ready = 1'b0;
    wait_done();
    report("valid");
    check_val("valid_pops", pop_count, 12);
    check_val("valid_success", 32'(cmd_decode_success), 32'd1);
    check_val("valid_bytes", 32'(cmd_bytes_processed), 32'd12);
    check_val("valid_r0_r3", {r0, r1, r2, r3}, 32'h01030B16);
    check_val("valid_r4_r7", {r4, r5, r6, r7}, 32'h21210000);
    check_val("valid_latency", lat, 24);
    repeat (5) @(negedge clk);
    check_val("valid_hold", 32'(cmd_processed), 32'd1);
    ack();
    repeat (4) @(negedge clk);
    check_val("no_retrigger_pops", pop_count, 12);
    check_val("result_hold", {r0, cmd_bytes_processed, 7'd0, cmd_decode_success, 8'd0}, 32'h010C0100);

    // Bad first byte: one pop, payload cleared
    load(128'h00FF0006_01030B16_2121EEEE_00000000, 12);
    start_decode();
    wait_done();
    report("bad_sof");
    check_val("sof_pops", pop_count, 1);
    check_val("sof_bytes_succ", {cmd_bytes_processed, 7'd0, cmd_decode_success}, 32'h0100);
    check_val("sof_payload", {r0, r5, r6, r7}, 32'd0);
    check_val("sof_latency", lat, 2);
    ack();

    // Missing SPACE byte
    load(128'hFFFF5506_01030B16_2121EEEE_00000000, 12);
    start_decode();
    wait_done();
    report("bad_space");
    check_val("space_bytes_succ", {cmd_bytes_processed, 7'd0, cmd_decode_success}, 32'h0300);
    ack();

    // LEN above the maximum
    load(128'hFFFF0009_01030B16_2121EEEE_00000000, 12);
    start_decode();
    wait_done();
    report("bad_len");
    check_val("len_bytes_succ", {cmd_bytes_processed, 7'd0, cmd_decode_success}, 32'h0400);
    check_val("len_pops", pop_count, 4);
    ack();

    // Bad first EOF byte after a full payload
    load(128'hFFFF0006_A1B2C3D4_E5F600EE_00000000, 12);
    start_decode();
    wait_done();
    report("bad_eof");
    check_val("eof_bytes_succ", {cmd_bytes_processed, 7'd0, cmd_decode_success}, 32'h0B00);
    check_val("eof_payload", {r0, r5, r6, r7}, 32'hA1F60000);
    ack();

    // Empty payload, then watchdog behaviour without an acknowledge
    load(128'hFFFF0000_EEEE0000_00000000_00000000, 6);
    start_decode();
    wait_done();
    report("len0");
    check_val("len0_bytes_succ", {cmd_bytes_processed, 7'd0, cmd_decode_success}, 32'h0601);
    check_val("len0_latency", lat, 12);
    hi_cnt = 1;
    for (int i = 0; i < 39; i++) begin
      @(negedge clk);
      if (cmd_processed) hi_cnt++;
      else break;
    end
`ifdef SERIAL_CMD_DECODER_ACK_TIMEOUT_EN
    check_val("ack_timeout", hi_cnt, 16);
`else
    check_val("ack_wait", hi_cnt, 40);
`endif
    $display("ack_window: processed_high_cycles=%0d", hi_cnt);
    check_val("len0_hold", {cmd_bytes_processed, 7'd0, cmd_decode_success}, 32'h0601);
    ack();

    // Asynchronous reset in the middle of a decode
    load(128'hFFFF0006_01030B16_2121EEEE_00000000, 12);
    start_decode();
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("midrst_outs", {cmd_read_clk, cmd_processed, cmd_decode_success, cmd_bytes_processed}, 32'd0);
    lat = pop_count;
    repeat (4) @(negedge clk);
    check_val("midrst_no_pop", pop_count, lat);
    $display("midrst: pops_at_reset=%0d", lat);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("midrst_idle", {cmd_read_clk, cmd_processed}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_cmd_decoder_core.md
Name: serial_cmd_decoder_core

Overview:
- Frame decoder between a byte FIFO (filled by the UART receiver) and the command processor.
- On a `cmd_ready` request it pops bytes one at a time from the FIFO and checks the frame format.
- It latches up to 8 payload bytes into registers, then reports success or failure through a processed/acknowledge handshake.
- Frame format: 0xFF 0xFF (SOF), 0x00 (SPACE), LEN, LEN payload bytes, 0xEE 0xEE (EOF).

Parameters:
- MAX_CMD_PAYLOAD_BYTES, 8: largest accepted LEN; fixed at 8 because there are eight payload registers. Values above 8 are not supported.
- ACK_TIMEOUT_CYCLES, 1024: watchdog length; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_ready  input  1  a complete frame is in the FIFO; level signal, and its rising edge starts a decode.
- data  input  8  FIFO output byte.
- cmd_processed_received  input  1  consumer acknowledge of `cmd_processed`.
- cmd_read_clk  output  1  FIFO pop strobe; one-cycle pulse per byte.
- cmd_processed  output  1  decode finished; held high until acknowledged.
- cmd_bytes_processed  output  8  number of bytes popped in the last decode.
- cmd_decode_success  output  1  1 = last frame valid.
- cmd_payload_r0 .. cmd_payload_r7  output  8 each  payload byte i; unused registers read 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE.
  - All outputs 0, including all payload registers.
  - Internal byte index and cmd_ready edge register cleared.
  - Reset mid-decode aborts the decode with no further pops.
- FIFO read timing: FIFO updates `data` on the edge where it samples pop=1; the decoder samples `data` on the following edge. Each byte costs 2 cycles.
- States:
  - IDLE: detect rising edge of cmd_ready at edge E0. On detection: clear r0..r7, cmd_bytes_processed and success, go to POP.
  - POP: cmd_read_clk=1 for exactly one cycle; increment cmd_bytes_processed; go to LATCH.
  - LATCH: check `data` against the expected field, then go to POP, DONE(success) or DONE(fail).
  - DONE: cmd_processed=1, result outputs stable. When cmd_processed_received=1, go to IDLE; cmd_processed falls on that edge.
- Byte checks, with index k = 0-based byte position in the frame:
  - k=0,1: must be 0xFF.
  - k=2: must be 0x00.
  - k=3: LEN. LEN > MAX_CMD_PAYLOAD_BYTES is a failure. LEN=0 is legal and proceeds directly to EOF.
  - k=4..3+LEN: stored into r(k-4).
  - Next two bytes: must be 0xEE. After the second 0xEE, go to DONE with success=1.
- Any mismatch: stop popping immediately, go to DONE with success=0. r registers keep whatever was stored so far.
- Timing:
  - Byte k is latched at edge E0+2k+2.
  - cmd_processed rises after edge E0+2N, where N = bytes popped.
  - Valid frame: N = LEN+6.
- cmd_ready edges arriving while not in IDLE are ignored. cmd_ready held high does not retrigger.
- Outputs are registered and hold until the next decode start or reset.
- No FIFO-empty check is made. Popping an empty FIFO returns undefined data, which decodes as a failure.

Optional Feature:
- Macro: SERIAL_CMD_DECODER_ACK_TIMEOUT_EN.
- With the macro: in DONE, a counter runs. If cmd_processed_received is not seen within ACK_TIMEOUT_CYCLES cycles, the decoder returns to IDLE and drops cmd_processed. Results still hold.
- Without the macro: DONE waits indefinitely for the acknowledge.

Test Plan:
- Valid frame FF FF 00 06 01 03 0B 16 21 21 EE EE, then cmd_ready pulse:
  - exactly 12 cmd_read_clk pulses.
  - success=1, cmd_bytes_processed=12.
  - r0..r5 = 01,03,0B,16,21,21; r6=r7=00.
  - cmd_processed high after E0+24.
- First byte 00 instead of FF -> success=0, cmd_bytes_processed=1, 1 pop only, r0..r7=0.
- Byte 2 = 0x55 (SPACE missing) -> success=0, cmd_bytes_processed=3.
- LEN=0x09 -> success=0, cmd_bytes_processed=4, no payload popped.
- Frame with LEN=6 and first EOF byte 0x00 -> success=0, cmd_bytes_processed=11, r0..r5 loaded.
- Handshake and retrigger:
  - cmd_processed stays high until cmd_processed_received.
  - A second cmd_ready edge during decode is ignored.
  - Asserting rst low mid-decode zeroes all outputs immediately.
  - With SERIAL_CMD_DECODER_ACK_TIMEOUT_EN and ACK_TIMEOUT_CYCLES=16, no acknowledge -> cmd_processed drops after 16 cycles.
